ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 Parameter IMG_W, default 160: stored pixels per line.
REQ-002 Parameter IMG_H, default 120: stored lines per frame.
REQ-003 Parameter DECIM, default 2: keep 1 of DECIM pixels horizontally and 1 of DECIM lines vertically.
REQ-004 Parameter Y_FIRST, default 1: 1 = luma is the first byte of each pixel pair (YUYV); 0 = second byte (UYVY).
REQ-005 pclk  in  1: camera pixel clock, the single clock; all logic on rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 enable  in  1: capture permitted.
REQ-008 continuous  in  1: 1 = capture every frame; 0 = single frame, then IDLE.
REQ-009 cam_vsync  in  1: camera VSYNC, high during vertical blanking.
REQ-010 cam_href  in  1: camera HREF, high during active line bytes.
REQ-011 cam_d  in  8: camera data byte.
REQ-012 wr_en  out  1: one-cycle RAM write strobe.
REQ-013 wr_addr  out  16: RAM write address.
REQ-014 wr_data  out  8: luma byte to store.
REQ-015 busy  out  1: high in WAIT_VSYNC and CAPTURE.
REQ-016 frame_done  out  1: one-cycle pulse at the end of each captured frame.

Function
REQ-017 cam_vsync, cam_href and cam_d SHALL be registered once on entry; all edge detection uses these registered copies.
REQ-018 FSM states SHALL be IDLE, WAIT_VSYNC, CAPTURE and DONE.
REQ-019 IDLE -> WAIT_VSYNC when enable=1.
REQ-020 WAIT_VSYNC -> CAPTURE on a registered vsync falling edge.
- Counters, byte phase and address clear on this transition.
REQ-021 CAPTURE -> DONE on a registered vsync rising edge, including mid-line.
REQ-022 DONE lasts exactly 1 cycle with frame_done=1.
- Next state is WAIT_VSYNC if enable=1 and continuous=1; otherwise IDLE.
REQ-023 Deasserting enable during CAPTURE does not abort.
- The frame completes, then the FSM enters IDLE.
REQ-024 Byte phase toggles on each cycle with registered href=1 and resets to 0 when href=0.
- The luma byte is the phase-0 byte if Y_FIRST=1, the phase-1 byte otherwise.
REQ-025 A pixel counter SHALL count luma bytes per line.
- A pixel is stored only if pixel_count mod DECIM = 0, line_count mod DECIM = 0, col < IMG_W and row < IMG_H.
REQ-026 The line counter increments on each registered href falling edge; the pixel counter and col clear at that edge.
REQ-027 wr_addr = row*IMG_W + col, formed incrementally (no multiplier); width is 16 bits.
REQ-028 Each store increments wr_addr by 1; addresses never exceed IMG_W*IMG_H-1, and writes beyond the limit are suppressed, never wrapped.
REQ-029 wr_en, wr_addr and wr_data SHALL be registered and valid together, 2 pclk cycles after the byte is present on cam_d.
REQ-030 A short frame (vsync rises before IMG_H rows) still produces frame_done; stored data is left as written.

Reset
REQ-031 On rst: FSM=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0; all counters, the byte phase and the input registers cleared.
REQ-032 Reset mid-frame takes effect immediately; no write strobe occurs while rst=1.

Configuration
REQ-033 With CAPTURE_STATS_EN defined, add output frame_count (8 bits) and output short_frame (1 bit).
- frame_count increments, wrapping, at each DONE.
- short_frame latches 1 at DONE if fewer than IMG_H rows were stored, and 0 otherwise.
- Both reset to 0.
REQ-034 Without CAPTURE_STATS_EN those ports and their logic are absent; all other behaviour is identical.

Structure
REQ-035 Shared package ov7670_pkg SHALL hold the FSM state enum, default IMG_W/IMG_H/DECIM and the address width (16).
REQ-036 Column/row/address counting SHALL be one sub-module, ov7670_pixel_counter; the FSM, input registers and strobe stay in ov7670_capture.

Verification
REQ-037 Defaults, Y_FIRST=1, 320x240 YUYV frame, Y byte = pixel index mod 256 -> 19200 writes, addr 0..19199, wr_data at addr 1 = 2, one frame_done.
REQ-038 Y_FIRST=0, same frame as UYVY -> identical wr_data sequence to REQ-037.
REQ-039 vsync rises after 50 camera lines -> 25 rows stored (addr max 3999), frame_done pulses; with CAPTURE_STATS_EN, short_frame=1.
REQ-040 continuous=0, three frames driven -> exactly one frame_done, then IDLE with busy=0.
REQ-041 Camera line of 400 luma bytes -> only 160 writes per kept row; no address past the row limit.
REQ-042 rst asserted mid-line, released, then a new frame -> outputs 0 during rst; capture restarts at addr 0 after the next vsync falling edge.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 luma capture slice.
package ov7670_pkg;

  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 120;
  localparam int DEF_DECIM = 2;
  localparam int ADDR_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VSYNC,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/ov7670_pixel_counter.sv
// Column/row/address tracking for decimated luma storage.
// The address is built from a running row base, so no multiplier is needed.
module ov7670_pixel_counter
  import ov7670_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DECIM = DEF_DECIM
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              clear,
  input  logic              luma,
  input  logic              line_end,
  output logic              store,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] row
);

  localparam logic [ADDR_W-1:0] W_L    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] H_L    = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] D_LAST = ADDR_W'(DECIM - 1);

  logic [ADDR_W-1:0] pix_ph;
  logic [ADDR_W-1:0] line_ph;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;

  assign store = luma && (pix_ph == '0) && (line_ph == '0) && (col < W_L) && (row < H_L);
  assign addr  = row_base + col;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pix_ph   <= '0;
      line_ph  <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (clear) begin
      pix_ph   <= '0;
      line_ph  <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      if (luma) begin
        pix_ph <= (pix_ph == D_LAST) ? '0 : pix_ph + 1'b1;
        if (store) col <= col + 1'b1;
      end
      if (line_end) begin
        pix_ph  <= '0;
        col     <= '0;
        line_ph <= (line_ph == D_LAST) ? '0 : line_ph + 1'b1;
        // only a kept line advances the stored row
        if ((line_ph == '0) && (row < H_L)) begin
          row      <= row + 1'b1;
          row_base <= row_base + W_L;
        end
      end
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 luma frame grabber: registers the camera bus, runs the capture FSM
// and issues RAM writes. Optional stats outputs via CAPTURE_STATS_EN.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int DECIM   = DEF_DECIM,
  parameter int Y_FIRST = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              continuous,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
`ifdef CAPTURE_STATS_EN
  ,
  output logic [7:0]        frame_count,
  output logic              short_frame
`endif
);

  localparam logic LUMA_PH = (Y_FIRST != 0) ? 1'b0 : 1'b1;

  cap_state_t        state, state_nxt;
  logic              vs_r, vs_q, href_r, href_q, phase;
  logic [7:0]        d_r;
  logic              vs_fall, vs_rise, line_end, luma, clear, store;
  logic [ADDR_W-1:0] addr, row;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_r   <= 1'b0;
      vs_q   <= 1'b0;
      href_r <= 1'b0;
      href_q <= 1'b0;
      d_r    <= '0;
    end else begin
      vs_r   <= cam_vsync;
      vs_q   <= vs_r;
      href_r <= cam_href;
      href_q <= href_r;
      d_r    <= cam_d;
    end
  end

  assign vs_fall  = vs_q & ~vs_r;
  assign vs_rise  = ~vs_q & vs_r;
  assign clear    = (state == ST_WAIT_VSYNC) && vs_fall;
  assign line_end = (state == ST_CAPTURE) && href_q && !href_r;
  assign luma     = (state == ST_CAPTURE) && href_r && (phase == LUMA_PH);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (enable) state_nxt = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vs_fall) state_nxt = ST_CAPTURE;
      ST_CAPTURE:    if (vs_rise) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = (enable && continuous) ? ST_WAIT_VSYNC : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ST_WAIT_VSYNC) || (state == ST_CAPTURE);
    frame_done = (state == ST_DONE);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                  phase <= 1'b0;
    else if (clear || !href_r) phase <= 1'b0;
    else                      phase <= ~phase;
  end

  ov7670_pixel_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DECIM (DECIM)
  ) u_cnt (
    .pclk     (pclk),
    .rst      (rst),
    .clear    (clear),
    .luma     (luma),
    .line_end (line_end),
    .store    (store),
    .addr     (addr),
    .row      (row)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= store;
      if (store) begin
        wr_addr <= addr;
        wr_data <= d_r;
      end
    end
  end

`ifdef CAPTURE_STATS_EN
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
      short_frame <= 1'b0;
    end else if (state == ST_DONE) begin
      frame_count <= frame_count + 1'b1;
      short_frame <= (row < ADDR_W'(IMG_H));
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench: YUYV and UYVY instances fed the same luma stream.
module tb_ov7670_capture;

  localparam int W = 20;
  localparam int H = 12;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        continuous = 1'b0;
  logic        vs = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  d_a = '0;
  logic [7:0]  d_b = '0;

  logic        wr_en_a, wr_en_b, busy_a, busy_b, fd_a, fd_b;
  logic [15:0] wr_addr_a, wr_addr_b;
  logic [7:0]  wr_data_a, wr_data_b;
`ifdef CAPTURE_STATS_EN
  logic [7:0]  fc_a, fc_b;
  logic        sf_a, sf_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  int n_wr_a = 0, n_wr_b = 0, mx_a = -1, mx_b = -1;
  int fd_a_cnt = 0, fd_b_cnt = 0;
  int exp_frames = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  ov7670_capture #(.IMG_W(W), .IMG_H(H), .DECIM(D), .Y_FIRST(1)) dut_a (
    .pclk(clk), .rst(rst), .enable(enable), .continuous(continuous),
    .cam_vsync(vs), .cam_href(href), .cam_d(d_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .frame_done(fd_a)
`ifdef CAPTURE_STATS_EN
    , .frame_count(fc_a), .short_frame(sf_a)
`endif
  );

  ov7670_capture #(.IMG_W(W), .IMG_H(H), .DECIM(D), .Y_FIRST(0)) dut_b (
    .pclk(clk), .rst(rst), .enable(enable), .continuous(continuous),
    .cam_vsync(vs), .cam_href(href), .cam_d(d_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .frame_done(fd_b)
`ifdef CAPTURE_STATS_EN
    , .frame_count(fc_b), .short_frame(sf_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (wr_en_a) begin
      if (q_a.size() == 0) check("unexp_wr_a", {8'h0, wr_addr_a, wr_data_a}, 32'hFFFFFFFF);
      else begin
        e = q_a.pop_front();
        check("addr_a", 32'(wr_addr_a), 32'(e[23:8]));
        check("data_a", 32'(wr_data_a), 32'(e[7:0]));
      end
      n_wr_a++;
      if (int'(wr_addr_a) > mx_a) mx_a = int'(wr_addr_a);
    end
    if (wr_en_b) begin
      if (q_b.size() == 0) check("unexp_wr_b", {8'h0, wr_addr_b, wr_data_b}, 32'hFFFFFFFF);
      else begin
        e = q_b.pop_front();
        check("addr_b", 32'(wr_addr_b), 32'(e[23:8]));
        check("data_b", 32'(wr_data_b), 32'(e[7:0]));
      end
      n_wr_b++;
      if (int'(wr_addr_b) > mx_b) mx_b = int'(wr_addr_b);
    end
    if (fd_a) fd_a_cnt++;
    if (fd_b) fd_b_cnt++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // luma of camera pixel p on line l is its frame index mod 256; chroma differs
  task automatic send_line(input int l, input int luma_n, input int npix, input bit cap, input bit end_line);
    logic [7:0] y, c;
    for (int p = 0; p < npix; p++) begin
      y = 8'((l * luma_n + p) % 256);
      c = y ^ 8'h5A;
      if (cap && (l % D == 0) && (p % D == 0) && (p / D < W) && (l / D < H)) begin
        q_a.push_back({16'((l / D) * W + p / D), y});
        q_b.push_back({16'((l / D) * W + p / D), y});
      end
      href = 1'b1; d_a = y; d_b = c;
      step(1);
      d_a = c; d_b = y;
      step(1);
    end
    if (end_line) begin
      href = 1'b0;
      step(6);
    end
  endtask

  task automatic drive_frame(input int lines, input int luma_n, input bit cap, input bit drop_en);
    vs = 1'b1;
    step(4);
    vs = 1'b0;
    step(4);
    if (drop_en) enable = 1'b0;
    for (int l = 0; l < lines; l++) send_line(l, luma_n, luma_n, cap, 1'b1);
    vs = 1'b1;
    step(8);
  endtask

  task automatic clr_stats();
    n_wr_a = 0; n_wr_b = 0; mx_a = -1; mx_b = -1;
  endtask

  task automatic frame_checks(input string tag, input int exp_wr, input int exp_mx);
    check({tag, "_nwr_a"}, n_wr_a, exp_wr);
    check({tag, "_nwr_b"}, n_wr_b, exp_wr);
    check({tag, "_max_a"}, mx_a, exp_mx);
    check({tag, "_max_b"}, mx_b, exp_mx);
    check({tag, "_qa_left"}, q_a.size(), 0);
    check({tag, "_qb_left"}, q_b.size(), 0);
    check({tag, "_fd_a"}, fd_a_cnt, exp_frames);
    check({tag, "_fd_b"}, fd_b_cnt, exp_frames);
`ifdef CAPTURE_STATS_EN
    check({tag, "_fc_a"}, fc_a, exp_fc);
    check({tag, "_fc_b"}, fc_b, exp_fc);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, {wr_en_b, wr_en_a}, 0);
    check({tag, "_wr_addr"}, {wr_addr_b, wr_addr_a}, 0);
    check({tag, "_wr_data"}, {wr_data_b, wr_data_a}, 0);
    check({tag, "_busy"}, {busy_b, busy_a}, 0);
    check({tag, "_fd"}, {fd_b, fd_a}, 0);
  endtask

  initial begin
    step(3);
    check_idle_outputs("rst");
`ifdef CAPTURE_STATS_EN
    check("rst_fc", {fc_b, fc_a}, 0);
    check("rst_sf", {sf_b, sf_a}, 0);
`endif
    rst = 1'b0;
    enable = 1'b1;
    continuous = 1'b1;
    step(3);
    check("armed_busy", {busy_b, busy_a}, 2'b11);

    clr_stats();
    drive_frame(2 * H, 2 * W, 1'b1, 1'b0);
    exp_frames++; exp_fc++;
    frame_checks("full", W * H, W * H - 1);
`ifdef CAPTURE_STATS_EN
    check("full_sf", {sf_b, sf_a}, 0);
`endif

    clr_stats();
    drive_frame(2 * H, 3 * W, 1'b1, 1'b0);
    exp_frames++; exp_fc++;
    frame_checks("wide", W * H, W * H - 1);

    clr_stats();
    drive_frame(10, 2 * W, 1'b1, 1'b0);
    exp_frames++; exp_fc++;
    frame_checks("short", 5 * W, 5 * W - 1);
`ifdef CAPTURE_STATS_EN
    check("short_sf", {sf_b, sf_a}, 2'b11);
`endif

    // single-shot: enable dropped mid-capture, frame still completes
    continuous = 1'b0;
    clr_stats();
    drive_frame(2 * H, 2 * W, 1'b1, 1'b1);
    drive_frame(2 * H, 2 * W, 1'b0, 1'b0);
    drive_frame(2 * H, 2 * W, 1'b0, 1'b0);
    exp_frames++; exp_fc++;
    frame_checks("single", W * H, W * H - 1);
    check("single_busy", {busy_b, busy_a}, 0);

    enable = 1'b1;
    continuous = 1'b1;
    step(3);
    vs = 1'b1; step(4);
    vs = 1'b0; step(4);
    send_line(0, 2 * W, 10, 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_idle_outputs($sformatf("midrst%0d", i));
    end
    href = 1'b0;
    vs = 1'b1;
    q_a.delete();
    q_b.delete();
    exp_fc = 0;
    rst = 1'b0;
    step(2);
    check("rearm_busy", {busy_b, busy_a}, 2'b11);
    clr_stats();
    drive_frame(2 * H, 2 * W, 1'b1, 1'b0);
    exp_frames++; exp_fc++;
    frame_checks("restart", W * H, W * H - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
